// File: rtl/noc_pkg.sv
// Shared types and helpers for the AXIS-to-flit injector.
package noc_pkg;

   // Destination width carried in the flit metadata ({tid,tdest} concatenated upstream).
   localparam int NOC_DEST_WIDTH = 6;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   typedef struct packed {
      logic [NOC_DEST_WIDTH-1:0] dest;
      logic                      is_tail;
   } flit_meta_t;

   // Credit counter must hold the value `depth` itself, hence depth+1 states.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/axis_flit_serializer_if.sv
// AXIS input beats plus the send/credit flit link of the local router port.
interface axis_flit_serializer_if #(
   parameter int TDATA_WIDTH          = 64,
   parameter int DEST_WIDTH           = 6,
   parameter int SERIALIZATION_FACTOR = 2
);
   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;

   logic                   axis_tvalid;
   logic                   axis_tready;
   logic [TDATA_WIDTH-1:0] axis_tdata;
   logic                   axis_tlast;
   logic [DEST_WIDTH-1:0]  axis_tdest;
   logic [FLIT_WIDTH-1:0]  data_out;
   logic [DEST_WIDTH-1:0]  dest_out;
   logic                   is_tail_out;
   logic                   send_out;
   logic                   credit_in;

   // The serializer: AXIS slave on the input, flit source on the link.
   modport slave (
      input  axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
      output axis_tready, data_out, dest_out, is_tail_out, send_out
   );

   // Upstream AXIS source and downstream router seen from outside.
   modport master (
      output axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
      input  axis_tready, data_out, dest_out, is_tail_out, send_out
   );
endinterface

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_rd_data while not empty.
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wr_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rd_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write port.
   // NOTE: the array is deliberately not reset; pointers/count define validity, and a reset on storage would block RAM inference.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers and occupancy; reset empties the FIFO and discards any buffered beats.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
endmodule

// File: rtl/axis_flit_serializer.sv
// AXIS beat buffer + serializer that injects flits into a router's local port under credit flow control.
module axis_flit_serializer
   import noc_pkg::*;
#(
   parameter int TDATA_WIDTH          = 64,
   parameter int DEST_WIDTH           = 6,
   parameter int SERIALIZATION_FACTOR = 2,
   parameter int BUFFER_DEPTH         = 4,
   parameter int FLIT_BUFFER_DEPTH    = 8
) (
   input  logic                   clk_noc,
   input  logic                   rst_noc,
   axis_flit_serializer_if.slave  bus
);
   localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
   localparam int ENTRY_W    = TDATA_WIDTH + 1 + DEST_WIDTH;
   localparam int CNT_W      = $clog2(BUFFER_DEPTH) + 1;
   localparam int CRED_W     = credit_width(FLIT_BUFFER_DEPTH);
   localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

   if (TDATA_WIDTH % SERIALIZATION_FACTOR != 0) begin : g_chk_div
      $error("TDATA_WIDTH must be divisible by SERIALIZATION_FACTOR");
   end
   if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("BUFFER_DEPTH must be a power of 2 and at least 2");
   end
   if (DEST_WIDTH != NOC_DEST_WIDTH) begin : g_chk_dest
      $error("DEST_WIDTH must match noc_pkg::NOC_DEST_WIDTH");
   end

   logic [ENTRY_W-1:0]     w_head;
   logic [TDATA_WIDTH-1:0] w_head_data;
   logic                   w_head_last;
   logic [DEST_WIDTH-1:0]  w_head_dest;
   logic                   w_empty;
   logic                   w_full;
   logic [CNT_W-1:0]       w_count;
   logic [CNT_W-1:0]       w_count_next;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_emit;
   logic                   w_credit_ok;
   logic [IDX_W-1:0]       w_sel;
   logic [IDX_W-1:0]       w_idx_next;
   logic [FLIT_WIDTH-1:0]  w_flit;
   ser_state_e             r_state;
   ser_state_e             w_state_next;
   logic [IDX_W-1:0]       r_idx;
   logic [CRED_W-1:0]      r_credits;
   logic                   r_tready;
   logic                   r_send;
   logic [FLIT_WIDTH-1:0]  r_data;
   flit_meta_t             r_meta;

   assign w_push = bus.axis_tvalid && r_tready;

   noc_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUFFER_DEPTH)
   ) u_beat_fifo (
      .i_clk     (clk_noc),
      .i_rst     (rst_noc),
      .i_push    (w_push),
      .i_wr_data ({bus.axis_tdata, bus.axis_tlast, bus.axis_tdest}),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (w_count)
   );

   assign w_head_data  = w_head[ENTRY_W-1 -: TDATA_WIDTH];
   assign w_head_last  = w_head[DEST_WIDTH];
   assign w_head_dest  = w_head[DEST_WIDTH-1:0];
   assign w_credit_ok  = (r_credits != '0);
   assign w_flit       = w_head_data[int'(w_sel)*FLIT_WIDTH +: FLIT_WIDTH];
   // tready is registered, so it is derived from the occupancy this edge will produce.
   assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

   // FSM state register.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // FSM next-state: stay in SEND until the last slice of the head beat leaves.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (!w_empty && w_credit_ok && SERIALIZATION_FACTOR > 1) w_state_next = SEND;
         SEND: if (w_credit_ok && r_idx == LAST_IDX)                    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs: which slice to emit, when to pop the head, next slice index.
   always_comb begin
      w_emit     = 1'b0;
      w_pop      = 1'b0;
      w_sel      = '0;
      w_idx_next = r_idx;
      case (r_state)
         IDLE: begin
            if (!w_empty && w_credit_ok) begin
               w_emit = 1'b1;
               if (SERIALIZATION_FACTOR == 1) w_pop = 1'b1;
               else                           w_idx_next = IDX_W'(1);
            end
         end
         SEND: begin
            if (w_credit_ok) begin
               w_emit = 1'b1;
               w_sel  = r_idx;
               if (r_idx == LAST_IDX) begin
                  w_pop      = 1'b1;
                  w_idx_next = '0;
               end else begin
                  w_idx_next = r_idx + IDX_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Slice index, AXIS ready and credit counter.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         r_idx     <= '0;
         r_tready  <= 1'b0;
         r_credits <= CRED_W'(FLIT_BUFFER_DEPTH);
      end else begin
         r_idx    <= w_idx_next;
         r_tready <= (w_count_next != CNT_W'(BUFFER_DEPTH));
         case ({bus.credit_in, w_emit})
            2'b10:   r_credits <= r_credits + CRED_W'(1);
            2'b01:   r_credits <= r_credits - CRED_W'(1);
            default: r_credits <= r_credits;
         endcase
      end
   end

   // Registered flit outputs; payload and dest hold between flits, tail drops to 0.
   always_ff @(posedge clk_noc or posedge rst_noc) begin
      if (rst_noc) begin
         r_send <= 1'b0;
         r_data <= '0;
         r_meta <= '0;
      end else begin
         r_send <= w_emit;
         if (w_emit) begin
            r_data         <= w_flit;
            r_meta.dest    <= w_head_dest;
            r_meta.is_tail <= w_pop && w_head_last;
         end else begin
            r_meta.is_tail <= 1'b0;
         end
      end
   end

   a_credit_max: assert property (@(posedge clk_noc) disable iff (rst_noc)
      r_credits <= CRED_W'(FLIT_BUFFER_DEPTH));

   assign bus.axis_tready = r_tready;
   assign bus.send_out    = r_send;
   assign bus.data_out    = r_data;
   assign bus.dest_out    = r_meta.dest;
   assign bus.is_tail_out = r_meta.is_tail;
endmodule
